nibble_add_seq: RTL and testbench
=================================

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
- REQ-001 The block SHALL have parameter NUM_NIBBLES, default 4; it sets the operand width in 4-bit nibbles (legal 2..16).
- REQ-002 The block SHALL derive localparam W = 4*NUM_NIBBLES as the operand width.
- REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
- REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
- REQ-006 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
- REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
- REQ-008 The block SHALL have ports A and B, input, W bits each: the operands.
- REQ-009 The block SHALL have port cin, input, 1 bit: the carry-in.
- REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is valid.
- REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
- REQ-012 The block SHALL have port S, output, W bits: the registered sum.
- REQ-013 The block SHALL have port cout, output, 1 bit: the registered carry-out of the top nibble.
- REQ-014 The block SHALL have port busy, output, 1 bit: high in any state except IDLE.

Function
- REQ-015 The block SHALL compute {cout,S} = A + B + cin using one shared 4-bit adder slice, one nibble per cycle, least significant nibble first.
- REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
- REQ-017 in_ready SHALL be 1 only in IDLE.
- REQ-018 When in_valid && in_ready in IDLE, the block SHALL latch A and B, set the carry register to cin, set nibble index idx to 0, and go to RUN.
- REQ-019 In each RUN cycle, the block SHALL write the slice sum of A[idx], B[idx] and the carry register into S[4*idx+:4], load the slice carry into the carry register, and increment idx.
- REQ-020 When the block processes idx == NUM_NIBBLES-1, it SHALL go to DONE and register the final carry into cout.
- REQ-021 out_valid SHALL be 1 only in DONE, first asserted NUM_NIBBLES+1 cycles after the accept edge (cycle 5 for the default).
- REQ-022 In DONE, S and cout SHALL hold stable until out_valid && out_ready; on that edge the block SHALL go to IDLE.
- REQ-023 No new operands SHALL be accepted in DONE; the minimum spacing between accepts is NUM_NIBBLES+2 cycles.
- REQ-024 A, B and cin changes after the accept edge SHALL be ignored.
- REQ-025 Carry SHALL propagate across all nibbles; wrap-around at 2^W SHALL appear only through cout.

Reset
- REQ-026 While rst is high at a clock edge, the block SHALL set the state to IDLE, idx to 0, the carry register, S and cout to 0, out_valid to 0 and busy to 0; in_ready SHALL be 1 after the reset edge.
- REQ-027 A reset in RUN or DONE SHALL abort the operation; no out_valid SHALL be produced for the aborted operands.
- REQ-028 If rst and in_valid are both high on the same edge, reset SHALL win and the operands SHALL NOT be accepted.

Configuration
- REQ-029 With NIBBLE_ADD_SEQ_OVF_EN defined, the block SHALL add output port ovf, 1 bit, registered with cout, equal to the two's-complement signed overflow (carry into the MSB XOR carry out of the MSB), and reset to 0.
- REQ-030 Without NIBBLE_ADD_SEQ_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour is identical.

Structure
- REQ-031 Shared package nibble_add_pkg SHALL hold NIBBLE_W = 4 and the state enum (IDLE, RUN, DONE).
- REQ-032 The block SHALL instantiate the existing 4-bit adder (adder4: S, cout, A, B, cin) exactly once as its only sub-module, used as the slice.
- REQ-033 The nibble mux, carry register, idx counter and FSM SHALL reside in nibble_add_seq.

Verification (NUM_NIBBLES=4)
- REQ-034 Accept A=0x1234, B=0x4321, cin=0 with out_ready=1: out_valid rises at cycle 5 with S=0x5555, cout=0.
- REQ-035 A=0xFFFF, B=0x0001, cin=0: S=0x0000, cout=1 (carry ripples across all 4 nibbles).
- REQ-036 A=0xFFFF, B=0xFFFF, cin=1: S=0xFFFF, cout=1; then out_ready held 0 for 3 cycles: S, cout and out_valid stay stable, in_ready=0; IDLE on the first cycle with out_ready=1.
- REQ-037 Assert rst in the 2nd RUN cycle: the next cycle shows IDLE, in_ready=1, S=0, no out_valid; a subsequent 0x0003+0x0005 gives 0x0008.
- REQ-038 Toggle A and B every cycle during RUN: the result matches the latched operands only.
- REQ-039 With NIBBLE_ADD_SEQ_OVF_EN defined: 0x7FFF+0x0001 gives ovf=1, S=0x8000; 0x8000+0xFFFF gives ovf=1, cout=1.

Source files
------------

// File: rtl/nibble_add_pkg.sv
// Shared constants and FSM state type for the nibble-serial adder.
package nibble_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/nibble_add_seq_if.sv
// Operand/result handshake bundle for nibble_add_seq.
// Carries the ovf result line only when NIBBLE_ADD_SEQ_OVF_EN is defined.
interface nibble_add_seq_if import nibble_add_pkg::*; #(
  parameter int NUM_NIBBLES = 4
);

  localparam int W = NIBBLE_W * NUM_NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         cout;
  logic         busy;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
  logic         ovf;
`endif

  modport master (
    output in_valid, A, B, cin, out_ready,
    input  in_ready, out_valid, S, cout,
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    input  ovf,
`endif
    input  busy
  );

  modport slave (
    input  in_valid, A, B, cin, out_ready,
    output in_ready, out_valid, S, cout,
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    output ovf,
`endif
    output busy
  );

endinterface

// File: rtl/adder4.sv
// Plain 4-bit ripple slice used as the shared nibble adder.
module adder4 (
  output logic [3:0] S,
  output logic       cout,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin
);

  assign {cout, S} = {1'b0, A} + {1'b0, B} + {4'b0000, cin};

endmodule

// File: rtl/nibble_add_seq.sv
// Nibble-serial adder: {cout,S} = A + B + cin, one nibble per cycle, LSN first.
// Define NIBBLE_ADD_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module nibble_add_seq import nibble_add_pkg::*; #(
  parameter int NUM_NIBBLES = 4
) (
  input logic             clk,
  input logic             rst,
  nibble_add_seq_if.slave bus
);

  localparam int W  = NIBBLE_W * NUM_NIBBLES;
  localparam int IW = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NIBBLES - 1);

  state_t                state;
  state_t                state_next;
  logic [IW-1:0]         idx;
  logic [W-1:0]          a_reg;
  logic [W-1:0]          b_reg;
  logic [W-1:0]          sum_reg;
  logic                  carry;
  logic                  cout_reg;
  logic [NIBBLE_W-1:0]   a_nib;
  logic [NIBBLE_W-1:0]   b_nib;
  logic [NIBBLE_W-1:0]   s_nib;
  logic                  c_nib;
  logic                  last;

  assign last  = (idx == LAST_IDX);
  assign a_nib = a_reg[NIBBLE_W*idx +: NIBBLE_W];
  assign b_nib = b_reg[NIBBLE_W*idx +: NIBBLE_W];

  adder4 slice (
    .S    (s_nib),
    .cout (c_nib),
    .A    (a_nib),
    .B    (b_nib),
    .cin  (carry)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state != IDLE);
  end

`ifdef NIBBLE_ADD_SEQ_OVF_EN
  logic ovf_reg;
  // Carry into the MSB is recovered from the top sum bit: a^b^s gives it back.
  always_ff @(posedge clk) begin
    if (rst)                       ovf_reg <= 1'b0;
    else if (state == RUN && last) ovf_reg <= a_nib[3] ^ b_nib[3] ^ s_nib[3] ^ c_nib;
  end
  assign bus.ovf = ovf_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.A;
            b_reg <= bus.B;
            carry <= bus.cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_reg[NIBBLE_W*idx +: NIBBLE_W] <= s_nib;
          carry <= c_nib;
          idx   <= last ? '0 : idx + 1'b1;
          if (last) cout_reg <= c_nib;
        end
        default: ;
      endcase
    end
  end

  assign bus.S    = sum_reg;
  assign bus.cout = cout_reg;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq: vector table, corner sequences, random ops vs. arithmetic model.
module tb_nibble_add_seq;
  import nibble_add_pkg::*;

  localparam int N = 4;
  localparam int W = NIBBLE_W * N;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] exp_s;
    logic         exp_cout;
    logic         exp_ovf;
    int           stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  nibble_add_seq_if #(.NUM_NIBBLES(N)) bus ();

  nibble_add_seq #(.NUM_NIBBLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // One full transaction: accept, scramble inputs during RUN, check latency, result and release.
  task automatic apply_stimulus(input vec_t v, input string name);
    int   waited;
    int   lat;
    logic [W-1:0] held_s;
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_output({name, " in_ready before accept"}, 64'(bus.in_ready), 64'(1));
    bus.A         = v.a;
    bus.B         = v.b;
    bus.cin       = v.c;
    bus.in_valid  = 1'b1;
    bus.out_ready = (v.stall == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 3 * N) begin
      bus.A   = W'($urandom);
      bus.B   = W'($urandom);
      bus.cin = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    check_output({name, " latency"}, 64'(lat), 64'(N));
    check_output({name, " S"}, 64'(bus.S), 64'(v.exp_s));
    check_output({name, " cout"}, 64'(bus.cout), 64'(v.exp_cout));
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    check_output({name, " ovf"}, 64'(bus.ovf), 64'(v.exp_ovf));
`endif
    check_output({name, " in_ready in DONE"}, 64'(bus.in_ready), 64'(0));
    held_s = bus.S;
    for (int i = 0; i < v.stall; i++) begin
      @(negedge clk);
      check_output({name, " stall S"}, 64'(bus.S), 64'(held_s));
      check_output({name, " stall out_valid"}, 64'(bus.out_valid), 64'(1));
      check_output({name, " stall in_ready"}, 64'(bus.in_ready), 64'(0));
      check_output({name, " stall cout"}, 64'(bus.cout), 64'(v.exp_cout));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_output({name, " back to idle"}, 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'(3'b100));
  endtask

  vec_t table_v[$];

  initial begin
    vec_t v;
    int   seen;
    logic [W:0] full;

    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;

    table_v.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0});
    table_v.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0});
    table_v.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 3});
    table_v.push_back('{16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0, 0});
    table_v.push_back('{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1});
    table_v.push_back('{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0});
    table_v.push_back('{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0});
    table_v.push_back('{16'h0FF0, 16'h0010, 1'b0, 16'h1000, 1'b0, 1'b0, 2});

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_output("reset state", 64'({bus.in_ready, bus.out_valid, bus.busy, bus.cout}), 64'(4'b1000));
    check_output("reset S", 64'(bus.S), 64'(0));
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    check_output("reset ovf", 64'(bus.ovf), 64'(0));
`endif

    foreach (table_v[i]) apply_stimulus(table_v[i], $sformatf("vec%0d", i));

    // Reset during the second RUN cycle must abort silently.
    bus.A        = 16'h1111;
    bus.B        = 16'h2222;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_output("abort busy in RUN", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("abort state", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'(3'b100));
    check_output("abort S", 64'(bus.S), 64'(0));
    seen = 0;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check_output("abort no out_valid", 64'(seen), 64'(0));
    apply_stimulus('{16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0, 0}, "after abort");

    // Reset and in_valid on the same edge: nothing accepted.
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.A        = 16'h0101;
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_output("rst beats in_valid", 64'(bus.busy), 64'(0));

    for (int i = 0; i < 20; i++) begin
      v.a      = W'($urandom);
      v.b      = W'($urandom);
      v.c      = 1'($urandom);
      full     = {1'b0, v.a} + {1'b0, v.b} + {{W{1'b0}}, v.c};
      v.exp_s  = full[W-1:0];
      v.exp_cout = full[W];
      v.exp_ovf  = model_ovf(v.a, v.b, v.c);
      v.stall  = int'($urandom_range(0, 2));
      apply_stimulus(v, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
